// File: rtl/fft_bfly_sched_if.sv
// ---------------------------------------------------------------------------
// fft_bfly_sched_if
// Bundles the control handshake and memory/datapath strobes of the radix-2
// butterfly scheduler.
//   master : FFT top-level side (drives start/stall, observes everything else)
//   slave  : scheduler side (fft_bfly_sched)
// Signals:
//   start, stall          control requests into the scheduler
//   busy, done, stage     run status
//   rd_en, rd_addr_a/b    butterfly issue to sample RAM
//   tw_idx                twiddle ROM index (W_N^tw_idx)
//   wr_en, wr_addr_a/b    write-back of both butterfly results
// ---------------------------------------------------------------------------
interface fft_bfly_sched_if #(
  parameter int LOG2N = 4
);
  logic             start;
  logic             stall;
  logic             busy;
  logic             done;
  logic [LOG2N-1:0] stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;

  modport master (
    output start, stall,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, stall,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_bfly_sched.sv
// ---------------------------------------------------------------------------
// fft_bfly_sched
// Sequencer for an in-place radix-2 DIT FFT that time-shares one butterfly
// datapath. Each unstalled ISSUE cycle emits one butterfly (two read
// addresses plus a twiddle index); the addresses are delayed PIPE_LAT cycles
// to form the write-back. Between stages the pipeline is drained so a read
// of stage s+1 never overtakes a write of stage s.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fft_bfly_sched_if.slave (start/stall in; busy, done, stage,
//          rd_en/rd_addr_a/rd_addr_b/tw_idx, wr_en/wr_addr_a/wr_addr_b out)
// Parameters:
//   LOG2N     log2 of FFT length (2..10)
//   PIPE_LAT  cycles from rd_en to wr_en (1..8)
// ---------------------------------------------------------------------------
module fft_bfly_sched #(
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_bfly_sched_if.slave     bus
);

  localparam int AW = LOG2N;
  localparam int KW = LOG2N - 1;
  localparam logic [AW-1:0] LAST_STAGE = AW'(LOG2N - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [KW-1:0]     r_k;
  logic [KW-1:0]     w_kNext;
  logic [AW-1:0]     r_stage;
  logic [AW-1:0]     w_stageNext;

  logic [PIPE_LAT-1:0]         r_pipeValid;
  logic [PIPE_LAT-1:0][AW-1:0] r_pipeA;
  logic [PIPE_LAT-1:0][AW-1:0] r_pipeB;

  logic              w_issue;
  logic              w_pend;
  logic [KW-1:0]     w_ones;
  logic [KW-1:0]     w_posMask;
  logic [KW-1:0]     w_pos;
  logic [KW-1:0]     w_grp;
  logic [AW-1:0]     w_half;
  logic [AW-1:0]     w_addrA;
  logic [AW-1:0]     w_addrB;
  logic [AW-1:0]     w_twShift;
  logic [KW-1:0]     w_tw;
  logic              w_wrEn;

  assign w_issue = (r_state == ISSUE) && !bus.stall;

  // Butterfly address decode from the registered (stage, k) pair.
  // posMask = half-1 computed in KW bits: for the last stage the shift
  // pushes every bit out and the mask becomes all ones, which is exactly
  // half-1 there as well.
  assign w_ones    = '1;
  assign w_posMask = ~(w_ones << r_stage);
  assign w_pos     = r_k & w_posMask;
  assign w_grp     = r_k >> r_stage;
  assign w_half    = {1'b0, w_posMask} + AW'(1);
  assign w_addrA   = (({1'b0, w_grp} << r_stage) << 1) | {1'b0, w_pos};
  assign w_addrB   = w_addrA | w_half;
  assign w_twShift = LAST_STAGE - r_stage;
  assign w_tw      = w_pos << w_twShift;

  // True while some write would still be in flight after the next shift.
  // The oldest slot is excluded: it retires in the current cycle, so the
  // next stage may start reading right after it.
  always_comb begin
    w_pend = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      w_pend = w_pend | r_pipeValid[i];
    end
  end

  // Next-state logic; a stall freezes everything, including IDLE.
  always_comb begin
    w_stateNext = r_state;
    w_kNext     = r_k;
    w_stageNext = r_stage;
    if (!bus.stall) begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_stateNext = ISSUE;
            w_kNext     = '0;
            w_stageNext = '0;
          end
        end
        ISSUE: begin
          w_kNext = r_k + KW'(1);
          if (r_k == '1) begin
            w_stateNext = DRAIN;
            w_kNext     = '0;
          end
        end
        DRAIN: begin
          if (!w_pend) begin
            if (r_stage == LAST_STAGE) begin
              w_stateNext = DONE;
            end else begin
              w_stateNext = ISSUE;
              w_stageNext = r_stage + AW'(1);
              w_kNext     = '0;
            end
          end
        end
        DONE: begin
          w_stateNext = IDLE;
          w_stageNext = '0;
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_stage <= '0;
    end else begin
      r_state <= w_stateNext;
      r_k     <= w_kNext;
      r_stage <= w_stageNext;
    end
  end

  // Write-back delay line: slot 0 takes the current issue, the last slot
  // drives the write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipeValid <= '0;
      r_pipeA     <= '0;
      r_pipeB     <= '0;
    end else if (!bus.stall) begin
      r_pipeValid[0] <= w_issue;
      r_pipeA[0]     <= w_addrA;
      r_pipeB[0]     <= w_addrB;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeA[i]     <= r_pipeA[i-1];
        r_pipeB[i]     <= r_pipeB[i-1];
      end
    end
  end

  assign w_wrEn = r_pipeValid[PIPE_LAT-1] && !bus.stall;

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE) && !bus.stall;
  assign bus.stage     = r_stage;
  assign bus.rd_en     = w_issue;
  assign bus.rd_addr_a = w_issue ? w_addrA : '0;
  assign bus.rd_addr_b = w_issue ? w_addrB : '0;
  assign bus.tw_idx    = w_issue ? w_tw : '0;
  assign bus.wr_en     = w_wrEn;
  assign bus.wr_addr_a = w_wrEn ? r_pipeA[PIPE_LAT-1] : '0;
  assign bus.wr_addr_b = w_wrEn ? r_pipeB[PIPE_LAT-1] : '0;

endmodule

// File: doc/fft_bfly_sched.md
Name: fft_bfly_sched

Overview:
Sequencer for an in-place radix-2 DIT FFT that time-shares a single butterfly datapath (the 16-bit Q15 complex multiplier plus add/sub) across all butterflies of all stages. Per cycle it issues one butterfly: two sample-memory read addresses and a twiddle-ROM index. It delays the addresses to generate the matching write-back, and drains the pipeline between stages so that no read can overtake a pending write. It sits between the FFT top-level control (start/done) and the sample RAM, twiddle ROM and butterfly datapath.

Parameters:
LOG2N, 4, log2 of FFT length N (N = 16 by default); legal range 2..10.
PIPE_LAT, 2, cycles from read issue (rd_en) to write-back (wr_en) through RAM read, multiplier and add/sub; legal range 1..8.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle request to run one full FFT; sampled only in IDLE.
stall  in  1  global hold; freezes issue, drain and write pipeline; the datapath honours the same signal.
busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
done  out  1  one-cycle pulse after the final write of the final stage.
stage  out  LOG2N bits  current stage index s.
rd_en  out  1  butterfly issue strobe.
rd_addr_a  out  LOG2N  top input address.
rd_addr_b  out  LOG2N  bottom input address.
tw_idx  out  LOG2N-1  twiddle ROM index (W_N^tw_idx).
wr_en  out  1  write-back strobe for both results.
wr_addr_a  out  LOG2N  write address for the a result.
wr_addr_b  out  LOG2N  write address for the b result.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters and the pipeline are cleared; all outputs are 0. Reset mid-FFT aborts immediately, with no done pulse.
- States:
  - IDLE: start=1 goes to ISSUE with s=0 and k=0. start is ignored in every other state.
  - ISSUE: one butterfly per cycle while stall=0, with k = 0..N/2-1. After k=N/2-1 it goes to DRAIN.
  - DRAIN: no issue. It stays until the write pipeline is empty. If s<LOG2N-1, it then goes to ISSUE with s+1 and k=0; otherwise it goes to DONE.
  - DONE: done=1 for one cycle, busy=1, then IDLE.
- Address generation for stage s and butterfly k:
  - half = 2^s; pos = k mod half; grp = k >> s.
  - rd_addr_a = grp*2^(s+1) + pos; rd_addr_b = rd_addr_a + half.
  - tw_idx = pos << (LOG2N-1-s).
  - The input is in bit-reversed order already; output is natural order.
- Outputs: rd_en/rd_addr_*/tw_idx are valid only in ISSUE with stall=0 and are decoded from registered counters; the address outputs read 0 when rd_en=0.
- Write pipeline: a PIPE_LAT-deep shift register of {valid, addr_a, addr_b}. wr_en and wr_addr_* appear exactly PIPE_LAT unstalled cycles after the matching rd_en.
- Stall: stall=1 holds every register (state, k, s, pipeline). rd_en and wr_en are forced to 0 during stall. Stall during DONE delays the done pulse.
- Timing with no stall: the stage period is N/2 + PIPE_LAT cycles. With start accepted at cycle 0, the first rd_en is at cycle 1 and done is at cycle LOG2N*(N/2+PIPE_LAT)+1.
- Hazard rule: the first read of stage s+1 occurs strictly after the last wr_en of stage s.

Test Plan:
- LOG2N=4, PIPE_LAT=2, start at cycle 0, no stall -> rd_en at cycles 1-8, 11-18, 21-28, 31-38; wr_en at 3-10, 13-20, 23-30, 33-40; done=1 only at cycle 41; busy high cycles 1-41.
- Address check, same run -> s0 k0: a=0 b=1 tw=0; s0 k1: a=2 b=3 tw=0; s1 k1: a=1 b=3 tw=4; s2 k5: a=9 b=13 tw=2; s3 k5: a=5 b=13 tw=5. Each wr_addr pair equals the rd pair from 2 cycles earlier.
- stall=1 for cycles 4-6 -> no rd_en or wr_en in cycles 4-6; the schedule shifts by 3 and done occurs at cycle 44; no address is skipped or duplicated.
- start pulsed again at cycle 15 -> ignored; single done at cycle 41; start at cycle 42 (IDLE) -> new run, first rd_en at cycle 43.
- rst_n=0 at cycle 20 -> all outputs 0 asynchronously; no done pulse; after release, start -> clean run from s=0, k=0.
- LOG2N=2, PIPE_LAT=1 -> rd pairs (0,1),(2,3) then (0,2) tw=0,(1,3) tw=1; done at cycle 7.
